// File: rtl/fetch_controller_if.sv
// Instruction-memory read port and fetch-to-decode handshake.
// The master side belongs to the fetch controller; the slave side is the
// memory/decode environment.
interface fetch_controller_if;
  // Instruction memory bus
  logic        imem_req;
  logic [15:0] imem_address;
  logic        imem_ack;
  logic [15:0] imem_data;

  // Fetch-to-decode handshake
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_address;
  logic        instr_ready;

  modport master (
    output imem_req,
    output imem_address,
    input  imem_ack,
    input  imem_data,
    output instr_valid,
    output instr,
    output instr_address,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_address,
    output imem_ack,
    output imem_data,
    input  instr_valid,
    input  instr,
    input  instr_address,
    output instr_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Single-entry instruction fetch controller.
// A four-state FSM issues one memory read, holds the returned word until
// decode takes it, then advances the PC and issues the next read. Halt and
// redirect preempt the in-flight fetch; halt is sticky until reset.
module fetch_controller #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 redirect_valid,
  input  logic [15:0]          redirect_address,
  fetch_controller_if.master   bus,
  output logic [15:0]          current_address,
  output logic                 halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic        w_capture;
  logic [15:0] r_instr;
  logic [15:0] r_instr_address;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic        r_halted;

  // Next-state and PC selection; priority is halt, redirect, ack/ready, start.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: begin
        // Redirects are meaningless before fetching starts.
        if (halt) begin
          w_state_next = HALTED;
        end else if (start) begin
          w_state_next = REQ;
        end
      end

      REQ: begin
        if (halt) begin
          w_state_next = HALTED;
        end else if (redirect_valid) begin
          // Same-cycle ack is dropped: its data belongs to the old stream.
          w_state_next = REQ;
          w_pc_next    = redirect_address;
        end else if (bus.imem_ack) begin
          w_state_next = HOLD;
          w_capture    = 1'b1;
        end
      end

      HOLD: begin
        if (halt) begin
          w_state_next = HALTED;
        end else if (redirect_valid) begin
          // The held instruction is discarded and the PC does not advance.
          w_state_next = REQ;
          w_pc_next    = redirect_address;
        end else if (bus.instr_ready) begin
          w_state_next = REQ;
          w_pc_next    = r_pc + PC_STEP;  // 16-bit add wraps silently
        end
      end

      HALTED: begin
        // Sticky: only reset leaves this state.
        w_state_next = HALTED;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, PC, captured instruction and registered output decodes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state         <= IDLE;
      r_pc            <= RESET_VECTOR;
      r_instr         <= 16'h0000;
      r_instr_address <= 16'h0000;
      r_imem_req      <= 1'b0;
      r_instr_valid   <= 1'b0;
      r_halted        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_imem_req    <= (w_state_next == REQ);
      r_instr_valid <= (w_state_next == HOLD);
      r_halted      <= (w_state_next == HALTED);
      if (w_capture) begin
        r_instr         <= bus.imem_data;
        r_instr_address <= r_pc;
      end
    end
  end

  assign bus.imem_req      = r_imem_req;
  assign bus.imem_address  = r_pc;
  assign bus.instr_valid   = r_instr_valid;
  assign bus.instr         = r_instr;
  assign bus.instr_address = r_instr_address;
  assign current_address   = r_pc;
  assign halted            = r_halted;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed testbench for fetch_controller: a table of per-cycle stimulus and
// expected outputs, plus hand-written reset, idle and halt sequences.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_address;
  logic [15:0] current_address;
  logic        halted;

  fetch_controller_if bus ();

  fetch_controller #(
    .RESET_VECTOR (16'h0000),
    .PC_STEP      (16'd1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .halt             (halt),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .bus              (bus.master),
    .current_address  (current_address),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        start;
    logic        halt;
    logic        rv;
    logic [15:0] raddr;
    logic        ack;
    logic [15:0] data;
    logic        ready;
    logic        e_req;
    logic        e_valid;
    logic        e_halted;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic e_req, input logic e_valid,
                            input logic e_halted, input logic [15:0] e_pc,
                            input logic [15:0] e_instr, input logic [15:0] e_iaddr);
    check({name, ".imem_req"},      {15'd0, bus.imem_req},    {15'd0, e_req});
    check({name, ".instr_valid"},   {15'd0, bus.instr_valid}, {15'd0, e_valid});
    check({name, ".halted"},        {15'd0, halted},          {15'd0, e_halted});
    check({name, ".pc"},            current_address,          e_pc);
    check({name, ".imem_address"},  bus.imem_address,         e_pc);
    check({name, ".instr"},         bus.instr,                e_instr);
    check({name, ".instr_address"}, bus.instr_address,        e_iaddr);
  endtask

  task automatic add(input string name, input logic st, input logic hl, input logic rv,
                     input logic [15:0] raddr, input logic ack, input logic [15:0] data,
                     input logic ready, input logic e_req, input logic e_valid,
                     input logic e_halted, input logic [15:0] e_pc,
                     input logic [15:0] e_instr, input logic [15:0] e_iaddr);
    vec_t v;
    v.name = name; v.start = st; v.halt = hl; v.rv = rv; v.raddr = raddr;
    v.ack = ack; v.data = data; v.ready = ready;
    v.e_req = e_req; v.e_valid = e_valid; v.e_halted = e_halted;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_iaddr = e_iaddr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic hl, input logic rv, input logic [15:0] raddr,
                       input logic ack, input logic [15:0] data, input logic ready);
    start = st; halt = hl; redirect_valid = rv; redirect_address = raddr;
    bus.imem_ack = ack; bus.imem_data = data; bus.instr_ready = ready;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive(0, 0, 0, 16'h0000, 0, 16'h0000, 0);

    // Fill the vector table (each row = inputs for one edge, outputs after it).
    //   name               st hl rv raddr     ack data      rdy req vld hlt pc        instr     iaddr
    add("fetch0_req",       1, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    add("fetch0_hold",      1, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 0, 1, 0, 16'h0000, 16'hA5A5, 16'h0000);
    add("fetch1_req",       1, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 1, 0, 0, 16'h0001, 16'hA5A5, 16'h0000);
    add("fetch1_hold",      1, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 0, 1, 0, 16'h0001, 16'hA5A5, 16'h0001);
    add("fetch2_req",       1, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 1, 0, 0, 16'h0002, 16'hA5A5, 16'h0001);
    add("fetch2_hold",      1, 0, 0, 16'h0000, 1, 16'hA5A5, 1, 0, 1, 0, 16'h0002, 16'hA5A5, 16'h0002);
    add("stall_enter",      0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 16'h0003, 16'hA5A5, 16'h0002);
    for (int i = 0; i < 5; i++)
      add("stall_wait",     0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 16'h0003, 16'hA5A5, 16'h0002);
    add("stall_ack",        0, 0, 0, 16'h0000, 1, 16'h1234, 0, 0, 1, 0, 16'h0003, 16'h1234, 16'h0003);
    add("hold_wait",        0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 16'h0003, 16'h1234, 16'h0003);
    add("redir_zero_hold",  0, 0, 1, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h1234, 16'h0003);
    add("redir_req_ack",    0, 0, 1, 16'h0010, 1, 16'hBEEF, 0, 1, 0, 0, 16'h0010, 16'h1234, 16'h0003);
    add("fetch10_hold",     0, 0, 0, 16'h0000, 1, 16'h5555, 0, 0, 1, 0, 16'h0010, 16'h5555, 16'h0010);
    add("redir_hold_100",   0, 0, 1, 16'h0100, 0, 16'h0000, 1, 1, 0, 0, 16'h0100, 16'h5555, 16'h0010);
    add("redir_ffff",       0, 0, 1, 16'hFFFF, 0, 16'h0000, 0, 1, 0, 0, 16'hFFFF, 16'h5555, 16'h0010);
    add("fetch_ffff_hold",  0, 0, 0, 16'h0000, 1, 16'h7777, 0, 0, 1, 0, 16'hFFFF, 16'h7777, 16'hFFFF);
    add("wrap",             0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h7777, 16'hFFFF);
    add("halt_over_redir",  0, 1, 1, 16'h0ABC, 1, 16'h1111, 0, 0, 0, 1, 16'h0000, 16'h7777, 16'hFFFF);
    add("halted_ignore",    1, 1, 1, 16'h0222, 1, 16'h2222, 1, 0, 0, 1, 16'h0000, 16'h7777, 16'hFFFF);
    add("halted_ignore2",   1, 0, 1, 16'h0333, 1, 16'h3333, 1, 0, 0, 1, 16'h0000, 16'h7777, 16'hFFFF);

    // Reset state.
    tick();
    reset = 1'b0;
    check_outs("reset", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // IDLE ignores redirect and stays put without start.
    drive(0, 0, 1, 16'h0055, 1, 16'hDEAD, 1);
    tick();
    check_outs("idle_ignore", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // Table-driven main sequence.
    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].rv, vecs[i].raddr,
            vecs[i].ack, vecs[i].data, vecs[i].ready);
      tick();
      check_outs(vecs[i].name, vecs[i].e_req, vecs[i].e_valid, vecs[i].e_halted,
                 vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_iaddr);
    end

    // Reset is the only exit from HALTED.
    drive(0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("halted_reset", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // Reset in HOLD with instr_ready high abandons the fetch, no increment.
    drive(1, 0, 0, 16'h0000, 1, 16'hC0DE, 0);
    tick();
    tick();
    check_outs("pre_reset_hold", 0, 1, 0, 16'h0000, 16'hC0DE, 16'h0000);
    drive(0, 0, 0, 16'h0000, 0, 16'h0000, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("reset_in_hold", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    drive(1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    tick();
    check_outs("first_req_after_reset", 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // Halt in HOLD wins over a same-cycle handshake.
    drive(0, 0, 0, 16'h0000, 1, 16'h4242, 0);
    tick();
    check_outs("hold_before_halt", 0, 1, 0, 16'h0000, 16'h4242, 16'h0000);
    drive(0, 1, 0, 16'h0000, 0, 16'h0000, 1);
    tick();
    check_outs("halt_in_hold", 0, 0, 1, 16'h0000, 16'h4242, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
